// File: rtl/cmsdk_apb4_eg_slave_reg_arb_if.sv
// rtl/cmsdk_apb4_eg_slave_reg_arb_if.sv - two-requester and register-block signal bundle for the arbiter
interface cmsdk_apb4_eg_slave_reg_arb_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 m0_req;
    logic                 m0_write;
    logic [ADDRWIDTH-1:0] m0_addr;
    logic [3:0]           m0_wstrb;
    logic [31:0]          m0_wdata;
    logic                 m0_ack;
    logic [31:0]          m0_rdata;

    logic                 m1_req;
    logic                 m1_write;
    logic [ADDRWIDTH-1:0] m1_addr;
    logic [3:0]           m1_wstrb;
    logic [31:0]          m1_wdata;
    logic                 m1_ack;
    logic [31:0]          m1_rdata;

    logic [ADDRWIDTH-1:0] addr;
    logic                 read_en;
    logic                 write_en;
    logic [3:0]           byte_strobe;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 busy;

    modport slave (
        input  m0_req, m0_write, m0_addr, m0_wstrb, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_write, m1_addr, m1_wstrb, m1_wdata,
        output m1_ack, m1_rdata,
        output addr, read_en, write_en, byte_strobe, wdata,
        input  rdata,
        output busy
    );

    modport master (
        output m0_req, m0_write, m0_addr, m0_wstrb, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_write, m1_addr, m1_wstrb, m1_wdata,
        input  m1_ack, m1_rdata,
        input  addr, read_en, write_en, byte_strobe, wdata,
        output rdata,
        input  busy
    );
endinterface

// File: rtl/cmsdk_apb4_eg_slave_reg_arb.sv
// rtl/cmsdk_apb4_eg_slave_reg_arb.sv - two-port register access arbiter; CMSDK_APB4_EG_SLAVE_REG_ARB_RR_EN selects round-robin
module cmsdk_apb4_eg_slave_reg_arb #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                               pclk,
    input  logic                               presetn,
    cmsdk_apb4_eg_slave_reg_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    // Command captured from the winner in IDLE; later requester activity is ignored.
    logic                 cmd_write_q;
    logic [ADDRWIDTH-1:0] cmd_addr_q;
    logic [3:0]           cmd_wstrb_q;
    logic [31:0]          cmd_wdata_q;
    logic [31:0]          hold_q;

    // Winner of the in-flight access; also the reference for round-robin fairness.
    logic                 last_grant_q;

    logic                 any_req;
    logic                 winner;
    logic                 sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [3:0]           sel_wstrb;
    logic [31:0]          sel_wdata;

    assign any_req = bus.m0_req | bus.m1_req;

`ifdef CMSDK_APB4_EG_SLAVE_REG_ARB_RR_EN
    assign winner = (bus.m0_req & bus.m1_req) ? ~last_grant_q : bus.m1_req;
`else
    assign winner = bus.m1_req & ~bus.m0_req;
`endif

    assign sel_write = winner ? bus.m1_write : bus.m0_write;
    assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    assign sel_wstrb = winner ? bus.m1_wstrb : bus.m0_wstrb;
    assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

    // State, command latch, grant record and read holding register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wstrb_q  <= 4'h0;
            cmd_wdata_q  <= 32'h0;
            hold_q       <= 32'h0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                cmd_write_q  <= sel_write;
                cmd_addr_q   <= sel_addr;
                cmd_wstrb_q  <= sel_wstrb;
                cmd_wdata_q  <= sel_wdata;
                last_grant_q <= winner;
            end
            if (state_q == ACCESS) begin
                hold_q <= cmd_write_q ? 32'h0 : bus.rdata;
            end
        end
    end

    // Next-state: IDLE waits for a request, ACCESS and RESP each last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register-block strobes and requester responses, zeroed outside their state.
    always_comb begin
        bus.addr        = '0;
        bus.read_en     = 1'b0;
        bus.write_en    = 1'b0;
        bus.byte_strobe = 4'h0;
        bus.wdata       = 32'h0;
        bus.m0_ack      = 1'b0;
        bus.m0_rdata    = 32'h0;
        bus.m1_ack      = 1'b0;
        bus.m1_rdata    = 32'h0;
        bus.busy        = (state_q != IDLE);
        if (state_q == ACCESS) begin
            bus.addr = cmd_addr_q;
            if (cmd_write_q) begin
                bus.write_en    = 1'b1;
                bus.byte_strobe = cmd_wstrb_q;
                bus.wdata       = cmd_wdata_q;
            end else begin
                bus.read_en = 1'b1;
            end
        end
        if (state_q == RESP) begin
            if (last_grant_q) begin
                bus.m1_ack   = 1'b1;
                bus.m1_rdata = hold_q;
            end else begin
                bus.m0_ack   = 1'b1;
                bus.m0_rdata = hold_q;
            end
        end
    end

endmodule
